// File: rtl/trigger_conditioner.sv
// Synchronises and debounces a raw start input and issues a single-cycle trigger with a
// captured delay setpoint, followed by a hold-off window and a release qualification.
module trigger_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 256,
  parameter int unsigned CNT_W           = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       raw_in,
  input  logic [7:0] delay_sel,
  output logic       trigger,
  output logic [7:0] delay_value,
  output logic       busy,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    FIRE,
    HOLD,
    REL
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trigger_q;
  logic [7:0]             delay_q;
  logic [7:0]             count_q;
  logic                   s_in;

  assign s_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_in) begin
            state_d = QUAL;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        QUAL: begin
          if (!s_in) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = FIRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        FIRE: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        REL: begin
          // Any high sample restarts the release qualification, so a held input never re-arms.
          if (s_in) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
      delay_q   <= '0;
      count_q   <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trigger_q <= (state_d == FIRE);
      if (state_d == FIRE) begin
        delay_q <= delay_sel;
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign trigger     = trigger_q;
  assign delay_value = delay_q;
  assign busy        = (state_q != IDLE);
  assign event_count = count_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Randomised bench for trigger_conditioner, checked against a run-length model of the
// press / hold-off / release rules.
module tb_trigger_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int HOLD = 32;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       raw_in;
  logic [7:0] delay_sel;
  logic       trigger;
  logic [7:0] delay_value;
  logic       busy;
  logic [7:0] event_count;

  trigger_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (HOLD),
    .CNT_W          (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .raw_in     (raw_in),
    .delay_sel  (delay_sel),
    .trigger    (trigger),
    .delay_value(delay_value),
    .busy       (busy),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: raw history, plus run lengths instead of explicit states.
  bit         hist[$];
  bit         armed   = 1'b1;
  int         run     = 0;
  int         ignore  = 0;
  int         low_run = 0;
  bit         m_trig  = 1'b0;
  bit         m_busy  = 1'b0;
  logic [7:0] m_dv    = 8'h00;
  logic [7:0] m_ec    = 8'h00;

  int edge_no         = 0;
  int dut_pulses      = 0;
  int mdl_pulses      = 0;
  int last_pulse_edge = 0;
  int lock_err        = 0;

  task automatic model_edge(input bit r, input bit e, input bit raw, input logic [7:0] dsel);
    bit s;
    m_trig = 1'b0;
    if (!r) begin
      hist.delete();
      armed = 1'b1; run = 0; ignore = 0; low_run = 0;
      m_dv = 8'h00; m_ec = 8'h00; m_busy = 1'b0;
      return;
    end
    s = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
    hist.push_front(raw);
    if (hist.size() > SYNC) void'(hist.pop_back());
    if (!e) begin
      armed = 1'b1; run = 0; ignore = 0; low_run = 0;
    end else if (armed) begin
      if (s) begin
        run++;
        if (run == DEB) begin
          m_trig = 1'b1; m_dv = dsel; m_ec = m_ec + 8'd1;
          armed = 1'b0; run = 0; ignore = HOLD + 1; low_run = 0;
        end
      end else begin
        run = 0;
      end
    end else if (ignore > 0) begin
      ignore--;
    end else if (s) begin
      low_run = 0;
    end else begin
      low_run++;
      if (low_run == DEB) armed = 1'b1;
    end
    m_busy = !(armed && run == 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    model_edge(reset, enable, raw_in, delay_sel);
    if (trigger === 1'b1) begin
      dut_pulses++;
      last_pulse_edge = edge_no;
    end
    if (m_trig) mdl_pulses++;
    if (trigger !== m_trig || busy !== m_busy || delay_value !== m_dv || event_count !== m_ec)
      lock_err++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; raw_in = 1'b0;
    steps(2);
    reset = 1'b1;
    steps(2);
    dut_pulses = 0; mdl_pulses = 0; lock_err = 0; edge_no = 0; last_pulse_edge = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; delay_sel = 8'h5a;
    for (int i = 0; i < 5; i++) begin
      raw_in = i[0];
      step();
    end
    n_chk++; if (trigger !== 1'b0) $display("FAIL reset_trigger got %b want 0", trigger); else n_pass++;
    n_chk++; if (delay_value !== 8'h00) $display("FAIL reset_delay got %h want 00", delay_value); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (event_count !== 8'h00) $display("FAIL reset_count got %h want 00", event_count); else n_pass++;
  endtask

  task automatic test_clean_press();
    do_reset();
    delay_sel = 8'hff; raw_in = 1'b1;
    steps(100);
    n_chk++; if (dut_pulses !== 1) $display("FAIL press_pulses got %0d want 1", dut_pulses); else n_pass++;
    n_chk++; if (last_pulse_edge !== SYNC + DEB) $display("FAIL press_latency got edge %0d want %0d", last_pulse_edge, SYNC + DEB); else n_pass++;
    n_chk++; if (delay_value !== 8'hff) $display("FAIL press_delay got %h want ff", delay_value); else n_pass++;
    n_chk++; if (event_count !== 8'd1) $display("FAIL press_count got %0d want 1", event_count); else n_pass++;
    raw_in = 1'b0;
    steps(30);
    n_chk++; if (busy !== 1'b0) $display("FAIL press_rearm busy got %b want 0", busy); else n_pass++;
    n_chk++; if (lock_err !== 0) $display("FAIL press_lockstep got %0d want 0", lock_err); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    delay_sel = 8'h33; raw_in = 1'b1;
    steps(10);
    raw_in = 1'b0;
    steps(20);
    n_chk++; if (dut_pulses !== 0) $display("FAIL glitch_pulses got %0d want 0", dut_pulses); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (event_count !== 8'd0) $display("FAIL glitch_count got %0d want 0", event_count); else n_pass++;
  endtask

  task automatic test_holdoff_release();
    bit idle_between = 1'b0;
    do_reset();
    delay_sel = 8'h44; raw_in = 1'b1;
    steps(20);
    for (int i = 0; i < 40; i++) begin
      raw_in = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (dut_pulses == 1 && busy === 1'b0) idle_between = 1'b1;
    end
    raw_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dut_pulses == 1 && busy === 1'b0) idle_between = 1'b1;
    end
    raw_in = 1'b1;
    steps(25);
    raw_in = 1'b0;
    steps(60);
    n_chk++; if (dut_pulses !== 2) $display("FAIL holdoff_pulses got %0d want 2", dut_pulses); else n_pass++;
    n_chk++; if (idle_between !== 1'b1) $display("FAIL holdoff_idle_between got %b want 1", idle_between); else n_pass++;
    n_chk++; if (lock_err !== 0) $display("FAIL holdoff_lockstep got %0d want 0", lock_err); else n_pass++;
  endtask

  task automatic test_capture();
    do_reset();
    delay_sel = 8'h10; raw_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (dut_pulses != 0) delay_sel = 8'h22;
    end
    raw_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      delay_sel = 8'($urandom);
      step();
    end
    n_chk++; if (delay_value !== 8'h10) $display("FAIL capture_hold got %h want 10", delay_value); else n_pass++;
    delay_sel = 8'h00; raw_in = 1'b1;
    steps(25);
    raw_in = 1'b0;
    steps(60);
    n_chk++; if (delay_value !== 8'h00) $display("FAIL capture_zero got %h want 00", delay_value); else n_pass++;
    n_chk++; if (event_count !== 8'd2) $display("FAIL capture_count got %0d want 2", event_count); else n_pass++;
    n_chk++; if (lock_err !== 0) $display("FAIL capture_lockstep got %0d want 0", lock_err); else n_pass++;
  endtask

  task automatic test_abort_and_wrap();
    int re_edge;
    do_reset();
    delay_sel = 8'h77; raw_in = 1'b1;
    steps(9);
    enable = 1'b0;
    steps(30);
    n_chk++; if (dut_pulses !== 0) $display("FAIL abort_enable_pulses got %0d want 0", dut_pulses); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_enable_busy got %b want 0", busy); else n_pass++;
    enable = 1'b1; re_edge = edge_no;
    steps(20);
    n_chk++; if (last_pulse_edge - re_edge !== DEB) $display("FAIL reenable_latency got %0d want %0d", last_pulse_edge - re_edge, DEB); else n_pass++;
    steps(10);
    reset = 1'b0; raw_in = 1'b0;
    step();
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (event_count !== 8'd0) $display("FAIL abort_reset_count got %0d want 0", event_count); else n_pass++;
    reset = 1'b1;
    steps(3);
    dut_pulses = 0; mdl_pulses = 0; lock_err = 0;
    for (int p = 0; p < 256; p++) begin
      delay_sel = 8'($urandom);
      raw_in = 1'b1;
      steps($urandom_range(DEB + SYNC + 2, 30));
      for (int i = 0; i < 15; i++) begin
        raw_in = 1'($urandom);
        step();
      end
      raw_in = 1'b0;
      steps($urandom_range(40, 55));
    end
    n_chk++; if (dut_pulses !== 256) $display("FAIL wrap_pulses got %0d want 256", dut_pulses); else n_pass++;
    n_chk++; if (event_count !== 8'h00) $display("FAIL wrap_count got %h want 00", event_count); else n_pass++;
    n_chk++; if (dut_pulses !== mdl_pulses) $display("FAIL wrap_model_pulses got %0d want %0d", dut_pulses, mdl_pulses); else n_pass++;
    n_chk++; if (lock_err !== 0) $display("FAIL wrap_lockstep got %0d want 0", lock_err); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; raw_in = 1'b0; delay_sel = 8'h00;
    test_reset();
    test_clean_press();
    test_glitch();
    test_holdoff_release();
    test_capture();
    test_abort_and_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
